// File: rtl/huffman_packer.sv
// huffman_packer
// Packs a stream of gray-level symbols into an MSB-first byte stream using a
// Huffman code table supplied by the upstream table builder.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-low reset
//   code_valid, HC, M      one-cycle table load (codes and right-aligned masks,
//                          symbol 1 in the top CW bits)
//   sym_valid/sym_ready    symbol handshake; sym_data in 1..SYM_NUM,
//                          sym_last marks the final symbol of a frame
//   out_valid/out_ready    byte handshake; out_data MSB holds the first code bit,
//                          out_last marks the final (zero-padded) byte
//   bit_total              code bits appended this frame (saturating)
//   done                   one-cycle pulse after the last byte handshake
//   err                    sticky illegal-symbol flag, cleared by a table load
module huffman_packer #(
  parameter int SYM_NUM = 6,
  parameter int CW      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  code_valid,
  input  logic [SYM_NUM*CW-1:0] HC,
  input  logic [SYM_NUM*CW-1:0] M,
  input  logic                  sym_valid,
  input  logic [7:0]            sym_data,
  input  logic                  sym_last,
  output logic                  sym_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [15:0]           bit_total,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Code length is the number of ones in the (contiguous) mask.
  function automatic logic [3:0] popcount(input logic [CW-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < CW; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  state_t                  state_r;
  logic [SYM_NUM*CW-1:0]   hc_r;
  logic [SYM_NUM*CW-1:0]   m_r;
  logic [15:0]             acc_r;
  logic [3:0]              cnt_r;
  logic [15:0]             bit_total_r;
  logic                    err_r;

  logic [CW-1:0]           code_s;
  logic [CW-1:0]           mask_s;
  logic                    legal_s;
  logic [3:0]              len_s;
  logic                    accept_s;
  logic                    byte_hs_s;
  logic [15:0]             acc_sh_s;
  logic [3:0]              cnt_sh_s;
  logic [4:0]              shamt_s;
  logic [15:0]             acc_app_s;
  logic [4:0]              cnt_app_s;
  logic [16:0]             bt_sum_s;
  logic [15:0]             bt_next_s;

  // Table lookup for the presented symbol; out-of-range symbols select nothing.
  always_comb begin
    code_s  = '0;
    mask_s  = '0;
    legal_s = 1'b0;
    for (int i = 0; i < SYM_NUM; i++) begin
      if (sym_data == 8'(i + 1)) begin
        code_s  = hc_r[(SYM_NUM-1-i)*CW +: CW] & m_r[(SYM_NUM-1-i)*CW +: CW];
        mask_s  = m_r[(SYM_NUM-1-i)*CW +: CW];
        legal_s = 1'b1;
      end else begin
      end
    end
  end

  assign len_s     = popcount(mask_s);
  assign sym_ready = (state_r == RUN) && (cnt_r < 4'd8);
  assign accept_s  = sym_valid && sym_ready;
  assign byte_hs_s = out_valid && out_ready;

  // Next accumulator contents: byte shift first, then append at the post-shift fill level.
  always_comb begin
    if (byte_hs_s) begin
      acc_sh_s = {acc_r[7:0], 8'h00};
      cnt_sh_s = (cnt_r >= 4'd8) ? (cnt_r - 4'd8) : 4'd0;
    end else begin
      acc_sh_s = acc_r;
      cnt_sh_s = cnt_r;
    end
    shamt_s = 5'd16 - {1'b0, cnt_sh_s} - {1'b0, len_s};
    if (accept_s) begin
      acc_app_s = acc_sh_s | (16'(code_s) << shamt_s);
      cnt_app_s = {1'b0, cnt_sh_s} + {1'b0, len_s};
    end else begin
      acc_app_s = acc_sh_s;
      cnt_app_s = {1'b0, cnt_sh_s};
    end
  end

  // Saturating running count of appended code bits.
  always_comb begin
    bt_sum_s = {1'b0, bit_total_r} + {13'd0, len_s};
    if (bt_sum_s[16]) begin
      bt_next_s = 16'hFFFF;
    end else begin
      bt_next_s = bt_sum_s[15:0];
    end
  end

  // Byte-valid decode from state and fill level only.
  always_comb begin
    case (state_r)
      RUN:     out_valid = (cnt_r >= 4'd8);
      FLUSH:   out_valid = (cnt_r != 4'd0);
      default: out_valid = 1'b0;
    endcase
  end

  // A sym_last frame always drains through FLUSH, so the final byte is the one
  // that leaves at most one byte's worth of bits.
  assign out_last  = (state_r == FLUSH) && (cnt_r != 4'd0) && (cnt_r <= 4'd8);
  assign out_data  = acc_r[15:8];
  assign done      = (state_r == DONE);
  assign bit_total = bit_total_r;
  assign err       = err_r;

  // Frame sequencing, table storage and bit accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      hc_r        <= '0;
      m_r         <= '0;
      acc_r       <= 16'h0000;
      cnt_r       <= 4'd0;
      bit_total_r <= 16'h0000;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (code_valid) begin
            hc_r        <= HC;
            m_r         <= M;
            acc_r       <= 16'h0000;
            cnt_r       <= 4'd0;
            bit_total_r <= 16'h0000;
            err_r       <= 1'b0;
            state_r     <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r <= acc_app_s;
          cnt_r <= cnt_app_s[3:0];
          if (accept_s) begin
            bit_total_r <= bt_next_s;
            if (!legal_s) begin
              err_r <= 1'b1;
            end else begin
              err_r <= err_r;
            end
            if (sym_last) begin
              state_r <= (cnt_app_s == 5'd0) ? DONE : FLUSH;
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= RUN;
          end
        end
        FLUSH: begin
          acc_r <= acc_sh_s;
          cnt_r <= cnt_sh_s;
          if (byte_hs_s && (cnt_r <= 4'd8)) begin
            state_r <= DONE;
          end else begin
            state_r <= FLUSH;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_packer.sv
// Directed testbench for huffman_packer. Expected bytes are hand-derived from
// the table: sym1 "1", sym2 "01", sym3 "001", sym4 "0001", sym5 "00001",
// sym6 "00000".
module tb_huffman_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        code_valid = 1'b0;
  logic [47:0] HC = 48'h0;
  logic [47:0] M = 48'h0;
  logic        sym_valid = 1'b0;
  logic [7:0]  sym_data = 8'h00;
  logic        sym_last = 1'b0;
  logic        sym_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic [15:0] bit_total;
  logic        done;
  logic        err;

  localparam logic [47:0] HC_T = 48'h01_01_01_01_01_00;
  localparam logic [47:0] M_T  = 48'h01_03_07_0F_1F_1F;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  logic [7:0] byte_q[$];
  logic       last_q[$];

  huffman_packer dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .HC(HC), .M(M),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last),
    .sym_ready(sym_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .bit_total(bit_total),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Byte collector: the handshake completes on the following rising edge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      byte_q.push_back(out_data);
      last_q.push_back(out_last);
      last_hs_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic load_table(input logic [47:0] hc, input logic [47:0] m);
    code_valid = 1'b1; HC = hc; M = m;
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic send_sym(input logic [7:0] s, input logic l);
    int n;
    sym_valid = 1'b1; sym_data = s; sym_last = l; n = 0;
    while (!sym_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (sym_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_sym_timeout: sym_ready=%b required 1 (sym %0d)", sym_ready, s);
    end
    @(posedge clk); #1;
    sym_valid = 1'b0; sym_last = 1'b0; sym_data = 8'h00;
  endtask

  task automatic wait_done(output bit found, output int at);
    found = 1'b0; at = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1; at = cyc;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_checks++;
    if ({sym_ready, out_valid, out_data, out_last, bit_total, done, err} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {sym_ready, out_valid, out_data, out_last, bit_total, done, err});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (sym_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_ready: got %b required 0", sym_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] eb [2] = '{8'hA4, 8'h00};
    logic       el [2] = '{1'b0, 1'b1};
    bit f; int at;
    byte_q.delete(); last_q.delete();
    load_table(HC_T, M_T);
    n_checks++;
    if (sym_ready !== 1'b1 || bit_total !== 16'd0) begin
      n_fail++; $display("FAIL basic_run_entry: ready=%b bt=%0d required 1/0", sym_ready, bit_total);
    end
    send_sym(8'd1, 1'b0); send_sym(8'd2, 1'b0); send_sym(8'd3, 1'b0); send_sym(8'd6, 1'b1);
    wait_done(f, at);
    n_checks++;
    if (f !== 1'b1 || at !== last_hs_cyc + 1) begin
      n_fail++; $display("FAIL basic_done_timing: found=%b at=%0d required at=%0d", f, at, last_hs_cyc + 1);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_pulse: done=%b required 0 one cycle later", done);
    end
    n_checks++;
    if (byte_q.size() != 2) begin
      n_fail++; $display("FAIL basic_count: got %0d bytes required 2", byte_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (byte_q.size() <= i || byte_q[i] !== eb[i] || last_q[i] !== el[i]) begin
        n_fail++; $display("FAIL basic_byte%0d: got %h/%b required %h/%b", i,
                           (byte_q.size() > i) ? byte_q[i] : 8'hxx,
                           (byte_q.size() > i) ? last_q[i] : 1'bx, eb[i], el[i]);
      end
    end
    n_checks++;
    if (bit_total !== 16'd11 || err !== 1'b0) begin
      n_fail++; $display("FAIL basic_bit_total: got %0d err=%b required 11 err=0", bit_total, err);
    end
  endtask

  task automatic test_full_byte();
    bit f; int at;
    byte_q.delete(); last_q.delete();
    load_table(HC_T, M_T);
    for (int i = 0; i < 8; i++) send_sym(8'd1, (i == 7));
    wait_done(f, at);
    n_checks++;
    if (f !== 1'b1 || byte_q.size() != 1) begin
      n_fail++; $display("FAIL full_count: found=%b bytes=%0d required 1/1", f, byte_q.size());
    end
    n_checks++;
    if (byte_q.size() < 1 || byte_q[0] !== 8'hFF || last_q[0] !== 1'b1) begin
      n_fail++; $display("FAIL full_byte: got %h/%b required ff/1",
                         (byte_q.size() > 0) ? byte_q[0] : 8'hxx,
                         (byte_q.size() > 0) ? last_q[0] : 1'bx);
    end
    n_checks++;
    if (bit_total !== 16'd8 || err !== 1'b0) begin
      n_fail++; $display("FAIL full_bit_total: got %0d err=%b required 8 err=0", bit_total, err);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] eb [3] = '{8'h08, 8'h42, 8'h10};
    logic       el [3] = '{1'b0, 1'b0, 1'b1};
    bit f; int at;
    byte_q.delete(); last_q.delete();
    out_ready = 1'b0;
    load_table(HC_T, M_T);
    send_sym(8'd5, 1'b0); send_sym(8'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (sym_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h08 || out_last !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: ready=%b valid=%b data=%h last=%b required 0/1/08/0",
                           i, sym_ready, out_valid, out_data, out_last);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_sym(8'd5, 1'b0); send_sym(8'd5, 1'b1);
    wait_done(f, at);
    n_checks++;
    if (f !== 1'b1 || byte_q.size() != 3) begin
      n_fail++; $display("FAIL bp_count: found=%b bytes=%0d required 1/3", f, byte_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (byte_q.size() <= i || byte_q[i] !== eb[i] || last_q[i] !== el[i]) begin
        n_fail++; $display("FAIL bp_byte%0d: got %h/%b required %h/%b", i,
                           (byte_q.size() > i) ? byte_q[i] : 8'hxx,
                           (byte_q.size() > i) ? last_q[i] : 1'bx, eb[i], el[i]);
      end
    end
    n_checks++;
    if (bit_total !== 16'd20) begin
      n_fail++; $display("FAIL bp_bit_total: got %0d required 20", bit_total);
    end
  endtask

  task automatic test_illegal();
    bit f; int at;
    byte_q.delete(); last_q.delete();
    load_table(HC_T, M_T);
    send_sym(8'd2, 1'b0); send_sym(8'd7, 1'b0);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL illegal_err_set: got %b required 1", err);
    end
    send_sym(8'd1, 1'b0); send_sym(8'd0, 1'b0); send_sym(8'd4, 1'b1);
    wait_done(f, at);
    n_checks++;
    if (f !== 1'b1 || byte_q.size() != 1 || byte_q[0] !== 8'h62 || last_q[0] !== 1'b1) begin
      n_fail++; $display("FAIL illegal_stream: found=%b bytes=%0d first=%h required 1/1/62",
                         f, byte_q.size(), (byte_q.size() > 0) ? byte_q[0] : 8'hxx);
    end
    n_checks++;
    if (err !== 1'b1 || bit_total !== 16'd7) begin
      n_fail++; $display("FAIL illegal_sticky: err=%b bt=%0d required 1/7", err, bit_total);
    end
    load_table(HC_T, M_T);
    n_checks++;
    if (err !== 1'b0 || bit_total !== 16'd0) begin
      n_fail++; $display("FAIL illegal_clear: err=%b bt=%0d required 0/0", err, bit_total);
    end
  endtask

  task automatic test_reset_mid();
    bit f; int at;
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    byte_q.delete(); last_q.delete();
    load_table(HC_T, M_T);
    send_sym(8'd0, 1'b0); send_sym(8'd5, 1'b0);
    n_checks++;
    if (err !== 1'b1 || bit_total !== 16'd5 || sym_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: err=%b bt=%0d ready=%b required 1/5/1", err, bit_total, sym_ready);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({sym_ready, out_valid, out_data, out_last, bit_total, done, err} !== 29'd0) begin
      n_fail++; $display("FAIL rstmid_async: got %h required 0",
                         {sym_ready, out_valid, out_data, out_last, bit_total, done, err});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (sym_ready !== 1'b0 || out_valid !== 1'b0 || byte_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_idle: ready=%b valid=%b bytes=%0d required 0/0/0",
                         sym_ready, out_valid, byte_q.size());
    end
    load_table(HC_T, M_T);
    send_sym(8'd4, 1'b0); send_sym(8'd3, 1'b1);
    wait_done(f, at);
    n_checks++;
    if (f !== 1'b1 || byte_q.size() != 1 || byte_q[0] !== 8'h12 || bit_total !== 16'd7) begin
      n_fail++; $display("FAIL rstmid_next: found=%b bytes=%0d first=%h bt=%0d required 1/1/12/7",
                         f, byte_q.size(), (byte_q.size() > 0) ? byte_q[0] : 8'hxx, bit_total);
    end
  endtask

  task automatic test_ignore_cv();
    bit f; int at;
    byte_q.delete(); last_q.delete();
    load_table(HC_T, M_T);
    send_sym(8'd1, 1'b0);
    load_table({6{8'hFF}}, {6{8'hFF}});
    send_sym(8'd2, 1'b0); send_sym(8'd1, 1'b1);
    wait_done(f, at);
    n_checks++;
    if (f !== 1'b1 || byte_q.size() != 1 || byte_q[0] !== 8'hB0 || last_q[0] !== 1'b1) begin
      n_fail++; $display("FAIL ignore_cv: found=%b bytes=%0d first=%h required 1/1/b0",
                         f, byte_q.size(), (byte_q.size() > 0) ? byte_q[0] : 8'hxx);
    end
    n_checks++;
    if (bit_total !== 16'd4) begin
      n_fail++; $display("FAIL ignore_cv_bt: got %0d required 4", bit_total);
    end
  endtask

  task automatic test_zero_mask();
    bit f; int at;
    byte_q.delete(); last_q.delete();
    load_table(HC_T, 48'h01_03_07_0F_1F_00);
    send_sym(8'd6, 1'b1);
    wait_done(f, at);
    n_checks++;
    if (f !== 1'b1 || byte_q.size() != 0 || bit_total !== 16'd0 || err !== 1'b0) begin
      n_fail++; $display("FAIL zero_mask: found=%b bytes=%0d bt=%0d err=%b required 1/0/0/0",
                         f, byte_q.size(), bit_total, err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_byte();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_ignore_cv();
    test_zero_mask();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
